rob_nway: RTL and testbench

Parametrised reorder buffer, the successor to the fixed 3-wide ROB. It dispatches, completes and retires up to `WIDTH` instructions per cycle in a `DEPTH`-entry circular buffer, and tracks occupancy with an explicit counter. Retirement is gated by store-queue capacity and is cut at the first mispredicted branch. That branch then raises a single-cycle flush with its recovery PC. The block sits between dispatch, the complete stage, the LSQ and the retire/recovery logic.

---
 rtl/sys_defs.sv | 47 ++++
 rtl/rob_retire_sel.sv | 51 +++++
 rtl/rob_nway.sv | 134 +++++++++++++
 tb/tb_rob_nway.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the reorder buffer: PC width, the ROB entry packet,
// and the branch-resolution helper used when an entry completes.
// Combinational helpers only; no state lives here.
package sys_defs;

    localparam int XLEN = 32;

    // One ROB slot. The branch fields come from dispatch; completed,
    // mispredict and target_pc are filled in by the complete stage.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] predict_pc;
        logic [XLEN-1:0] target_pc;
        logic            predict_taken;
        logic            is_store;
        logic            completed;
        logic            mispredict;
    } ROB_ENTRY_PACKET;

    typedef struct packed {
        logic            mispredict;
        logic [XLEN-1:0] target;
    } resolve_t;

    // Compares the resolved branch against its prediction. A wrong direction
    // or a taken branch with the wrong target both need recovery; the
    // recovery PC is the fall-through when the branch turned out not taken.
    function automatic resolve_t resolve_branch(input ROB_ENTRY_PACKET e,
                                                input logic taken,
                                                input logic [XLEN-1:0] target);
        resolve_t r;
        r = '0;
        if (e.predict_taken && !taken) begin
            r.mispredict = 1'b1;
            r.target     = e.npc;
        end else if (!e.predict_taken && taken) begin
            r.mispredict = 1'b1;
            r.target     = target;
        end else if (e.predict_taken && taken && (target != e.predict_pc)) begin
            r.mispredict = 1'b1;
            r.target     = target;
        end
        return r;
    endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Retire selection: picks the contiguous run of retiring head entries.
// Purely combinational; ports: head_entry/count/sq_retire_cap in,
// ret_valid/ret_count/flush/flush_pc out. Backpressure comes from the SQ cap.
module rob_retire_sel
    import sys_defs::*;
#(
    parameter int WIDTH = 3,
    parameter int IDX   = 5
) (
    input  ROB_ENTRY_PACKET [WIDTH-1:0] head_entry,
    input  logic [IDX:0]                count,
    input  logic [IDX:0]                sq_retire_cap,
    output logic [WIDTH-1:0]            ret_valid,
    output logic [IDX:0]                ret_count,
    output logic                        flush,
    output logic [XLEN-1:0]             flush_pc
);

    logic         open;
    logic [IDX:0] stores;
    logic [IDX:0] stores_next;

    // The run stays open while lanes retire; the first lane that cannot
    // retire, or a retiring mispredict, closes it for all younger lanes.
    always_comb begin
        ret_valid   = '0;
        ret_count   = '0;
        flush       = 1'b0;
        flush_pc    = '0;
        stores      = '0;
        stores_next = '0;
        open        = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            stores_next = stores + (IDX+1)'(head_entry[i].is_store);
            if (open && ((IDX+1)'(i) < count) && head_entry[i].completed &&
                (stores_next <= sq_retire_cap)) begin
                ret_valid[i] = 1'b1;
                ret_count    = ret_count + (IDX+1)'(1);
                stores       = stores_next;
                if (head_entry[i].mispredict) begin
                    flush    = 1'b1;
                    flush_pc = head_entry[i].target_pc;
                    open     = 1'b0;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer: circular entry array with head/tail/count, dispatch
// allocation, completion update and retire; all outputs combinational from state.
// Ports: disp_* (alloc), cmp_* (complete), sq_retire_cap, ret_* and flush/flush_pc.
module rob_nway
    import sys_defs::*;
#(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 3,
    parameter  int XLEN  = 32,
    localparam int IDX   = $clog2(DEPTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             disp_valid,
    input  ROB_ENTRY_PACKET [WIDTH-1:0]  disp_entry,
    output logic [WIDTH-1:0]             disp_accept,
    output logic [WIDTH-1:0][IDX-1:0]    disp_idx,
    output logic [IDX:0]                 free_slots,
    input  logic [WIDTH-1:0]             cmp_valid,
    input  logic [WIDTH-1:0][IDX-1:0]    cmp_idx,
    input  logic [WIDTH-1:0]             cmp_taken,
    input  logic [WIDTH-1:0][XLEN-1:0]   cmp_target,
    input  logic [IDX:0]                 sq_retire_cap,
    output logic [WIDTH-1:0]             ret_valid,
    output ROB_ENTRY_PACKET [WIDTH-1:0]  ret_entry,
    output logic                         flush,
    output logic [XLEN-1:0]              flush_pc
);

    localparam int PXLEN = sys_defs::XLEN;

    ROB_ENTRY_PACKET entries [DEPTH];
    logic [IDX-1:0]  head;
    logic [IDX-1:0]  tail;
    logic [IDX:0]    count;

    logic [IDX:0]    ret_count;
    logic [IDX:0]    disp_count;
    logic            sel_flush;
    logic [PXLEN-1:0] sel_flush_pc;
    resolve_t        cmp_res [WIDTH];
    ROB_ENTRY_PACKET disp_wr [WIDTH];
    logic [WIDTH-1:0] disp_valid_inc;

    assign free_slots = (IDX+1)'(DEPTH) - count;
    assign flush      = sel_flush;
    assign flush_pc   = XLEN'(sel_flush_pc);

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            ret_entry[i] = entries[head + IDX'(i)];
        end
    end

    rob_retire_sel #(.WIDTH(WIDTH), .IDX(IDX)) u_retire_sel (
        .head_entry    (ret_entry),
        .count         (count),
        .sq_retire_cap (sq_retire_cap),
        .ret_valid     (ret_valid),
        .ret_count     (ret_count),
        .flush         (sel_flush),
        .flush_pc      (sel_flush_pc)
    );

    // Allocation uses start-of-cycle free space only; slots freed by this
    // cycle's retire become visible next cycle. A flush discards dispatch.
    always_comb begin
        disp_accept = '0;
        disp_count  = '0;
        disp_idx    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            disp_idx[i] = tail + IDX'(i);
            disp_wr[i]  = disp_entry[i];
            disp_wr[i].completed  = 1'b0;
            disp_wr[i].mispredict = 1'b0;
            if (disp_valid[i] && ((IDX+1)'(i) < free_slots) && !sel_flush && !reset) begin
                disp_accept[i] = 1'b1;
                disp_count     = disp_count + (IDX+1)'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cmp_res[i] = resolve_branch(entries[cmp_idx[i]], cmp_taken[i],
                                        PXLEN'(cmp_target[i]));
        end
    end

    // Retire clears, completion updates and dispatch writes never land on the
    // same slot: completions target unretired entries and dispatch only
    // fills slots that were free at the start of the cycle.
    always_ff @(posedge clock) begin
        if (reset || sel_flush) begin
            for (int d = 0; d < DEPTH; d++) begin
                entries[d] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (ret_valid[i]) begin
                    entries[head + IDX'(i)] <= '0;
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (cmp_valid[i]) begin
                    entries[cmp_idx[i]].completed  <= 1'b1;
                    entries[cmp_idx[i]].mispredict <= cmp_res[i].mispredict;
                    entries[cmp_idx[i]].target_pc  <= cmp_res[i].target;
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (disp_accept[i]) begin
                    entries[disp_idx[i]] <= disp_wr[i];
                end
            end
            head  <= head + ret_count[IDX-1:0];
            tail  <= tail + disp_count[IDX-1:0];
            count <= count + disp_count - ret_count;
        end
    end

    // Valid dispatch lanes must form a run starting at lane 0.
    assign disp_valid_inc = disp_valid + WIDTH'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ((disp_valid & disp_valid_inc) == '0);
        end
    end

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway (DEPTH=8, WIDTH=3): directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_rob_nway;
    import sys_defs::*;

    localparam int D = 8;
    localparam int W = 3;

    logic                    clock;
    logic                    reset;
    logic [W-1:0]            disp_valid;
    ROB_ENTRY_PACKET [W-1:0] disp_entry;
    logic [W-1:0]            disp_accept;
    logic [W-1:0][2:0]       disp_idx;
    logic [3:0]              free_slots;
    logic [W-1:0]            cmp_valid;
    logic [W-1:0][2:0]       cmp_idx;
    logic [W-1:0]            cmp_taken;
    logic [W-1:0][31:0]      cmp_target;
    logic [3:0]              sq_retire_cap;
    logic [W-1:0]            ret_valid;
    ROB_ENTRY_PACKET [W-1:0] ret_entry;
    logic                    flush;
    logic [31:0]             flush_pc;

    rob_nway #(.DEPTH(D), .WIDTH(W), .XLEN(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .disp_valid    (disp_valid),
        .disp_entry    (disp_entry),
        .disp_accept   (disp_accept),
        .disp_idx      (disp_idx),
        .free_slots    (free_slots),
        .cmp_valid     (cmp_valid),
        .cmp_idx       (cmp_idx),
        .cmp_taken     (cmp_taken),
        .cmp_target    (cmp_target),
        .sq_retire_cap (sq_retire_cap),
        .ret_valid     (ret_valid),
        .ret_entry     (ret_entry),
        .flush         (flush),
        .flush_pc      (flush_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: in-flight entries in age order, each tagged with its slot.
    typedef struct {
        ROB_ENTRY_PACKET p;
        int              idx;
    } ment_t;

    ment_t q[$];
    int    mtail = 0;

    always @(negedge clock) begin : model_chk
        int nv, k, r, st, room;
        logic fl;
        logic [31:0] fpc;
        logic [W-1:0] erv, eacc;
        ment_t m;
        logic mis;
        if (reset) begin
            q.delete();
            mtail = 0;
        end else begin
            erv = '0; r = 0; st = 0; fl = 1'b0; fpc = '0;
            for (int i = 0; i < W; i++) begin
                if (i >= q.size()) break;
                if (!q[i].p.completed) break;
                if (st + int'(q[i].p.is_store) > int'(sq_retire_cap)) break;
                st += int'(q[i].p.is_store);
                erv[i] = 1'b1;
                r++;
                if (q[i].p.mispredict) begin
                    fl  = 1'b1;
                    fpc = q[i].p.target_pc;
                    break;
                end
            end
            nv   = $countones(disp_valid);
            room = D - q.size();
            k    = fl ? 0 : ((nv < room) ? nv : room);
            eacc = W'((1 << k) - 1);
            check("m_free", 192'(free_slots), 192'(room));
            check("m_accept", 192'(disp_accept), 192'(eacc));
            check("m_ret_valid", 192'(ret_valid), 192'(erv));
            check("m_flush", 192'(flush), 192'(fl));
            check("m_flush_pc", 192'(flush_pc), 192'(fpc));
            for (int i = 0; i < W; i++)
                check("m_disp_idx", 192'(disp_idx[i]), 192'((mtail + i) % D));
            for (int i = 0; i < r; i++)
                check("m_ret_entry", 192'(ret_entry[i]), 192'(q[i].p));
            if (fl) begin
                q.delete();
                mtail = 0;
            end else begin
                for (int i = 0; i < r; i++) m = q.pop_front();
                for (int l = 0; l < W; l++) begin
                    if (cmp_valid[l]) begin
                        for (int j = 0; j < q.size(); j++) begin
                            if (q[j].idx == int'(cmp_idx[l])) begin
                                m = q[j];
                                mis = (m.p.predict_taken != cmp_taken[l]) ||
                                      (cmp_taken[l] && (cmp_target[l] != m.p.predict_pc));
                                m.p.completed  = 1'b1;
                                m.p.mispredict = mis;
                                m.p.target_pc  = !mis ? 32'h0 : (cmp_taken[l] ? cmp_target[l] : m.p.npc);
                                q[j] = m;
                            end
                        end
                    end
                end
                for (int i = 0; i < k; i++) begin
                    m.p = disp_entry[i];
                    m.p.completed  = 1'b0;
                    m.p.mispredict = 1'b0;
                    m.idx = (mtail + i) % D;
                    q.push_back(m);
                end
                mtail = (mtail + k) % D;
            end
        end
    end

    // Dispatched flags are deliberately set so the DUT must clear them.
    function automatic ROB_ENTRY_PACKET mk(input logic [31:0] pc, input logic pt,
                                           input logic [31:0] ppc, input logic st);
        ROB_ENTRY_PACKET e;
        e.pc            = pc;
        e.npc           = pc + 32'd4;
        e.predict_pc    = ppc;
        e.target_pc     = 32'hdead_0000 | pc;
        e.predict_taken = pt;
        e.is_store      = st;
        e.completed     = 1'b1;
        e.mispredict    = 1'b1;
        return e;
    endfunction

    function automatic ROB_ENTRY_PACKET ent(input int n);
        if (n == 7) return mk(32'h100, 1'b1, 32'h200, 1'b0);
        return mk(32'h100 + 32'(4 * n), 1'b0, 32'h0, (n == 3) || (n == 5));
    endfunction

    task automatic clear_inputs();
        disp_valid    = '0;
        disp_entry    = '0;
        cmp_valid     = '0;
        cmp_idx       = '0;
        cmp_taken     = '0;
        cmp_target    = '0;
        sq_retire_cap = 4'd8;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic set_disp(input int n, input logic [31:0] base);
        disp_valid = W'((1 << n) - 1);
        for (int i = 0; i < W; i++) disp_entry[i] = mk(base + 32'(4 * i), 1'b0, 32'h0, 1'b0);
    endtask

    task automatic set_cmp(input int lane, input int idx, input logic taken);
        cmp_valid[lane]  = 1'b1;
        cmp_idx[lane]    = 3'(idx);
        cmp_taken[lane]  = taken;
        cmp_target[lane] = 32'h0;
    endtask

    initial begin
        int n, j;
        logic pt, tk;
        bit picked [D];
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        set_disp(3, 32'h100);
        settle();
        check("reset_accept", 192'(disp_accept), 192'(0));
        step();
        reset = 1'b0;
        settle();
        check("reset_free", 192'(free_slots), 192'(8));
        check("reset_ret_valid", 192'(ret_valid), 192'(0));
        check("reset_flush", 192'(flush), 192'(0));
        check("reset_flush_pc", 192'(flush_pc), 192'(0));
        check("reset_disp_idx", 192'(disp_idx[0]), 192'(0));

        // Fill: accepts 3,3,2,0
        step(); disp_valid = 3'b111; for (int i = 0; i < W; i++) disp_entry[i] = ent(i);
        settle();
        check("fill1_accept", 192'(disp_accept), 192'(3'b111));
        check("fill1_free", 192'(free_slots), 192'(8));
        check("fill1_idx", 192'(disp_idx[0]), 192'(0));
        step(); disp_valid = 3'b111; for (int i = 0; i < W; i++) disp_entry[i] = ent(3 + i);
        settle();
        check("fill2_accept", 192'(disp_accept), 192'(3'b111));
        check("fill2_free", 192'(free_slots), 192'(5));
        check("fill2_idx", 192'(disp_idx[0]), 192'(3));
        step(); disp_valid = 3'b111; for (int i = 0; i < W; i++) disp_entry[i] = ent(6 + i);
        settle();
        check("fill3_accept", 192'(disp_accept), 192'(3'b011));
        check("fill3_free", 192'(free_slots), 192'(2));
        check("fill3_idx0", 192'(disp_idx[0]), 192'(6));
        check("fill3_idx1", 192'(disp_idx[1]), 192'(7));
        step(); set_disp(3, 32'h900);
        settle();
        check("fill4_accept", 192'(disp_accept), 192'(0));
        check("fill4_free", 192'(free_slots), 192'(0));

        // Out-of-order completion
        step(); set_cmp(0, 2, 1'b0); settle();
        check("ooo_rv_a", 192'(ret_valid), 192'(0));
        step(); set_cmp(0, 1, 1'b0); settle();
        check("ooo_rv_b", 192'(ret_valid), 192'(0));
        step(); set_cmp(0, 0, 1'b0); settle();
        check("ooo_rv_c", 192'(ret_valid), 192'(0));
        step(); settle();
        check("ooo_rv_d", 192'(ret_valid), 192'(3'b111));
        check("ooo_pc0", 192'(ret_entry[0].pc), 192'(32'h100));
        check("ooo_pc1", 192'(ret_entry[1].pc), 192'(32'h104));
        check("ooo_pc2", 192'(ret_entry[2].pc), 192'(32'h108));

        // Store gating: store, ALU, store with one SQ slot per cycle
        step(); set_cmp(0, 3, 1'b0); set_cmp(1, 4, 1'b0); set_cmp(2, 5, 1'b0); settle();
        check("sq_free", 192'(free_slots), 192'(3));
        step(); sq_retire_cap = 4'd1; settle();
        check("sq_rv1", 192'(ret_valid), 192'(3'b011));
        step(); sq_retire_cap = 4'd1; settle();
        check("sq_rv2", 192'(ret_valid), 192'(3'b001));

        // Mispredict at head+1 (predicted taken, resolves not taken)
        step(); disp_valid = 3'b001; disp_entry[0] = mk(32'h300, 1'b0, 32'h0, 1'b0); settle();
        check("mp_accept", 192'(disp_accept), 192'(3'b001));
        check("mp_idx", 192'(disp_idx[0]), 192'(0));
        step(); set_cmp(0, 6, 1'b0); set_cmp(1, 7, 1'b0); set_cmp(2, 0, 1'b0); settle();
        step(); set_disp(3, 32'h500); settle();
        check("mp_rv", 192'(ret_valid), 192'(3'b011));
        check("mp_flush", 192'(flush), 192'(1));
        check("mp_flush_pc", 192'(flush_pc), 192'(32'h104));
        check("mp_accept_drop", 192'(disp_accept), 192'(0));
        step(); settle();
        check("mp_after_free", 192'(free_slots), 192'(8));
        check("mp_after_flush", 192'(flush), 192'(0));
        check("mp_after_idx", 192'(disp_idx[0]), 192'(0));

        // Wrap: walk head/tail to 6, fill, then retire while full
        step(); set_disp(3, 32'h400);
        step(); set_disp(3, 32'h40c); set_cmp(0, 0, 1'b0); set_cmp(1, 1, 1'b0); set_cmp(2, 2, 1'b0);
        step(); set_cmp(0, 3, 1'b0); set_cmp(1, 4, 1'b0); set_cmp(2, 5, 1'b0);
        step();
        step(); set_disp(3, 32'h600);
        step(); set_disp(3, 32'h60c);
        step(); set_disp(3, 32'h618); settle();
        check("wrap_fill_accept", 192'(disp_accept), 192'(3'b011));
        step(); set_cmp(0, 6, 1'b0); set_cmp(1, 7, 1'b0); settle();
        check("wrap_full_free", 192'(free_slots), 192'(0));
        check("wrap_full_idx", 192'(disp_idx[0]), 192'(6));
        step(); set_disp(3, 32'h700); settle();
        check("wrap_rv", 192'(ret_valid), 192'(3'b011));
        check("wrap_full_accept", 192'(disp_accept), 192'(0));
        step(); set_disp(3, 32'h700); settle();
        check("wrap_free2", 192'(free_slots), 192'(2));
        check("wrap_accept2", 192'(disp_accept), 192'(3'b011));
        check("wrap_idx6", 192'(disp_idx[0]), 192'(6));
        check("wrap_idx7", 192'(disp_idx[1]), 192'(7));
        step(); settle();
        check("wrap_tail0", 192'(disp_idx[0]), 192'(0));
        check("wrap_free0", 192'(free_slots), 192'(0));

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            step();
            reset = ($urandom_range(399) == 0);
            n = $urandom_range(3);
            disp_valid = W'((1 << n) - 1);
            for (int l = 0; l < W; l++)
                disp_entry[l] = mk($urandom, 1'($urandom_range(1)),
                                   32'h1000 + 32'(16 * $urandom_range(3)), 1'($urandom_range(1)));
            for (int d = 0; d < D; d++) picked[d] = 1'b0;
            for (int l = 0; l < W; l++) begin
                if (q.size() > 0 && $urandom_range(9) < 6) begin
                    j = $urandom_range(q.size() - 1);
                    if (!q[j].p.completed && !picked[q[j].idx]) begin
                        picked[q[j].idx] = 1'b1;
                        pt = q[j].p.predict_taken;
                        tk = ($urandom_range(15) == 0) ? ~pt : pt;
                        cmp_valid[l]  = 1'b1;
                        cmp_idx[l]    = 3'(q[j].idx);
                        cmp_taken[l]  = tk;
                        cmp_target[l] = ($urandom_range(7) == 0) ? $urandom : q[j].p.predict_pc;
                    end
                end
            end
            sq_retire_cap = ($urandom_range(4) == 0) ? 4'd8 : 4'($urandom_range(3));
        end
        step();
        reset = 1'b0;
        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
